// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART byte transmitter between N_REQ requesters.
// Optional stall watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  // state  | meaning
  // IDLE   | no owner; arbitrate from ptr+1 upward
  // LOCKED | owner_q holds the transmitter until its last byte (or a forced release)

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ out of range 2..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 2");
  end

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              found;
  logic [PW-1:0]     win;
  int                idx;
  logic              slot_free;
  logic              xfer;
  logic [7:0]        lane_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]     stall_q, stall_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // The only combinational path into the requesters is tx_ready_i -> req_ready_o.
  assign slot_free = !tx_valid_q || tx_ready_i;
  assign xfer      = (state_q == S_LOCKED) && req_valid_i[owner_q] && slot_free;
  assign lane_byte = req_data_i[owner_q*8 +: 8];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_LOCKED;
          owner_d      = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      S_LOCKED: begin
        if (xfer && req_last_i[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!req_valid_i[owner_q] && stall_q == SW'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          ptr_d     = owner_q;
          timeout_d = 1'b1;
        end
        if (xfer || state_d == S_IDLE) stall_d = '0;
        else if (!req_valid_i[owner_q]) stall_d = stall_q + 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // A load and a drain in the same cycle keep the register full.
    if (xfer) begin
      tx_valid_d = 1'b1;
      tx_data_d  = lane_byte;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(N_REQ - 1);
      owner_q    <= '0;
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign req_ready_o = (state_q == S_LOCKED) ? (grant_q & {N_REQ{slot_free}}) : '0;
  assign grant_o     = grant_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = (state_q == S_LOCKED) || tx_valid_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule
